// File: rtl/spi_flash_scheduler.sv
// SPI flash port owner: power-up reset sequence, then round-robin
// sharing of the flash pads between requester A and requester B.
//
// Ports:
//   io_clock, io_reset        clock, sync active-high reset
//   io_reqX_req/gnt           request / grant for requester X (A, B)
//   io_reqX_ss/sclk/mosi      requester X SPI outputs
//   io_spi_ss/sclk/mosi       flash pads, owner pass-through
//   io_spi_rst/wp/hold        flash control pins, active low
//   io_writeProtect           1 asserts flash write protect
//   io_flashReset             pulse, reruns the reset sequence
//   io_ready                  arbitration active
//   io_timeout                pulse on forced grant release
module spi_flash_scheduler #(
  parameter int RST_CYCLES       = 16,
  parameter int RECOVERY_CYCLES  = 64,
  parameter int GAP_CYCLES       = 4,
  parameter int MAX_GRANT_CYCLES = 0
) (
  input  logic io_clock,
  input  logic io_reset,
  input  logic io_reqA_req,
  output logic io_reqA_gnt,
  input  logic io_reqA_ss,
  input  logic io_reqA_sclk,
  input  logic io_reqA_mosi,
  input  logic io_reqB_req,
  output logic io_reqB_gnt,
  input  logic io_reqB_ss,
  input  logic io_reqB_sclk,
  input  logic io_reqB_mosi,
  output logic io_spi_ss,
  output logic io_spi_sclk,
  output logic io_spi_mosi,
  output logic io_spi_rst,
  output logic io_spi_wp,
  output logic io_spi_hold,
  input  logic io_writeProtect,
  input  logic io_flashReset,
  output logic io_ready,
  output logic io_timeout
);

  localparam int PMAX0 = (RST_CYCLES > RECOVERY_CYCLES) ?
                         RST_CYCLES : RECOVERY_CYCLES;
  localparam int PMAX  = (PMAX0 > GAP_CYCLES) ? PMAX0 : GAP_CYCLES;
  localparam int CW    = $clog2(PMAX + 1);
  localparam int GW    = (MAX_GRANT_CYCLES > 0) ?
                         $clog2(MAX_GRANT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (MAX_GRANT_CYCLES > 0);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVERY_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GNT_LAST =
    GW'((MAX_GRANT_CYCLES > 0) ? MAX_GRANT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_RST,
    S_REC,
    S_IDLE,
    S_GNT_A,
    S_GNT_B,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            last_b_q, last_b_d;
  logic            blk_a_q, blk_a_d;
  logic            blk_b_q, blk_b_d;
  logic            pend_q, pend_d;
  logic            tmo_q, tmo_d;
  logic            wp_q;

  logic el_a, el_b, own_req;

  assign el_a    = io_reqA_req & ~blk_a_q;
  assign el_b    = io_reqB_req & ~blk_b_q;
  assign own_req = (state_q == S_GNT_A) ? io_reqA_req : io_reqB_req;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    last_b_d = last_b_q;
    pend_d   = pend_q;
    tmo_d    = 1'b0;
    // a timed-out requester stays blocked until it lets go of req
    blk_a_d  = blk_a_q & io_reqA_req;
    blk_b_d  = blk_b_q & io_reqB_req;
    unique case (state_q)
      S_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d = S_REC;
          cnt_d   = '0;
        end
      end
      S_REC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == REC_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (io_flashReset) begin
          state_d = S_RST;
          cnt_d   = '0;
        end else if (el_a && (!el_b || last_b_q)) begin
          state_d = S_GNT_A;
          gcnt_d  = '0;
        end else if (el_b) begin
          state_d = S_GNT_B;
          gcnt_d  = '0;
        end
      end
      S_GNT_A, S_GNT_B: begin
        if (io_flashReset) pend_d = 1'b1;
        if (!own_req) begin
          state_d  = S_GAP;
          cnt_d    = '0;
          last_b_d = (state_q == S_GNT_B);
        end else if (TMO_EN && gcnt_q == GNT_LAST) begin
          state_d  = S_GAP;
          cnt_d    = '0;
          last_b_d = (state_q == S_GNT_B);
          tmo_d    = 1'b1;
          if (state_q == S_GNT_A) blk_a_d = 1'b1;
          else                    blk_b_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (io_flashReset) pend_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          // a deferred flash reset wins over any waiting requester
          if (pend_q || io_flashReset) begin
            state_d = S_RST;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      state_q  <= S_RST;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      last_b_q <= 1'b1;
      blk_a_q  <= 1'b0;
      blk_b_q  <= 1'b0;
      pend_q   <= 1'b0;
      tmo_q    <= 1'b0;
      wp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      last_b_q <= last_b_d;
      blk_a_q  <= blk_a_d;
      blk_b_q  <= blk_b_d;
      pend_q   <= pend_d;
      tmo_q    <= tmo_d;
      wp_q     <= ~io_writeProtect;
    end
  end

  // reset gating makes grant and pads drop in the same cycle
  always_comb begin
    io_spi_ss   = 1'b1;
    io_spi_sclk = 1'b0;
    io_spi_mosi = 1'b0;
    if (!io_reset) begin
      if (state_q == S_GNT_A) begin
        io_spi_ss   = io_reqA_ss;
        io_spi_sclk = io_reqA_sclk;
        io_spi_mosi = io_reqA_mosi;
      end else if (state_q == S_GNT_B) begin
        io_spi_ss   = io_reqB_ss;
        io_spi_sclk = io_reqB_sclk;
        io_spi_mosi = io_reqB_mosi;
      end
    end
  end

  assign io_reqA_gnt = (state_q == S_GNT_A) & ~io_reset;
  assign io_reqB_gnt = (state_q == S_GNT_B) & ~io_reset;
  assign io_spi_rst  = (state_q != S_RST) & ~io_reset;
  assign io_ready    = ((state_q == S_IDLE) |
                        (state_q == S_GNT_A) |
                        (state_q == S_GNT_B) |
                        (state_q == S_GAP)) & ~io_reset;
  assign io_spi_wp   = wp_q;
  assign io_spi_hold = 1'b1;
  assign io_timeout  = tmo_q;

endmodule

// File: tb/tb_spi_flash_scheduler.sv
// Bench for spi_flash_scheduler: reset sequence, arbitration,
// pass-through, gap, timeout, io_reset and deferred flash reset.
module tb_spi_flash_scheduler;

  logic clk;
  logic rst;
  logic a_req, a_ss, a_sclk, a_mosi;
  logic b_req, b_ss, b_sclk, b_mosi;
  logic a_gnt, b_gnt;
  logic spi_ss, spi_sclk, spi_mosi;
  logic spi_rst, spi_wp, spi_hold;
  logic wprot, frst, ready, tmo;

  int nchk = 0;
  int nerr = 0;

  spi_flash_scheduler #(
    .RST_CYCLES(16),
    .RECOVERY_CYCLES(64),
    .GAP_CYCLES(4),
    .MAX_GRANT_CYCLES(10)
  ) dut (
    .io_clock(clk),
    .io_reset(rst),
    .io_reqA_req(a_req),
    .io_reqA_gnt(a_gnt),
    .io_reqA_ss(a_ss),
    .io_reqA_sclk(a_sclk),
    .io_reqA_mosi(a_mosi),
    .io_reqB_req(b_req),
    .io_reqB_gnt(b_gnt),
    .io_reqB_ss(b_ss),
    .io_reqB_sclk(b_sclk),
    .io_reqB_mosi(b_mosi),
    .io_spi_ss(spi_ss),
    .io_spi_sclk(spi_sclk),
    .io_spi_mosi(spi_mosi),
    .io_spi_rst(spi_rst),
    .io_spi_wp(spi_wp),
    .io_spi_hold(spi_hold),
    .io_writeProtect(wprot),
    .io_flashReset(frst),
    .io_ready(ready),
    .io_timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected grant owners: 0 = A, 1 = B
  logic gq[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always @(negedge clk) begin
    if ((a_gnt && !prev_a) || (b_gnt && !prev_b)) begin
      if (gq.size() == 0) begin
        check("unexpected_grant", {6'd0, b_gnt, a_gnt}, 8'd0);
      end else begin
        logic e;
        e = gq.pop_front();
        check("grant_owner", {7'd0, b_gnt}, {7'd0, e});
        check("grant_onehot", {7'd0, a_gnt & b_gnt}, 8'd0);
      end
    end
    prev_a <= a_gnt;
    prev_b <= b_gnt;
  end

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] exp;
  } vec_t;

  vec_t tv[6];
  logic [2:0] pq[$];

  // release reset just after an edge, then walk the sequence
  task automatic release_seq();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 81; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_pin_k%0d", k), {7'd0, spi_rst},
            {7'd0, k >= 16});
      check($sformatf("ready_k%0d", k), {7'd0, ready},
            {7'd0, k >= 80});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int n;
    logic seen;
    logic [2:0] e;

    tv[0] = '{a: 3'b000, b: 3'b111, exp: 3'b000};
    tv[1] = '{a: 3'b010, b: 3'b101, exp: 3'b010};
    tv[2] = '{a: 3'b001, b: 3'b010, exp: 3'b001};
    tv[3] = '{a: 3'b011, b: 3'b110, exp: 3'b011};
    tv[4] = '{a: 3'b100, b: 3'b001, exp: 3'b100};
    tv[5] = '{a: 3'b111, b: 3'b000, exp: 3'b111};

    rst = 1'b1; wprot = 1'b0; frst = 1'b0;
    a_req = 1'b0; a_ss = 1'b1; a_sclk = 1'b0; a_mosi = 1'b0;
    b_req = 1'b0; b_ss = 1'b1; b_sclk = 1'b0; b_mosi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt_a", {7'd0, a_gnt}, 8'd0);
    check("rst_gnt_b", {7'd0, b_gnt}, 8'd0);
    check("rst_ss", {7'd0, spi_ss}, 8'd1);
    check("rst_sclk", {7'd0, spi_sclk}, 8'd0);
    check("rst_mosi", {7'd0, spi_mosi}, 8'd0);
    check("rst_pin", {7'd0, spi_rst}, 8'd0);
    check("rst_wp", {7'd0, spi_wp}, 8'd0);
    check("rst_hold", {7'd0, spi_hold}, 8'd1);
    check("rst_ready", {7'd0, ready}, 8'd0);
    check("rst_timeout", {7'd0, tmo}, 8'd0);

    release_seq();
    check("wp_after_rst", {7'd0, spi_wp}, 8'd1);

    // both request together: first arbitration goes to A
    @(posedge clk); #1;
    a_req = 1'b1; b_req = 1'b1;
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    @(posedge clk);
    @(negedge clk);
    check("both_gnt_a", {7'd0, a_gnt}, 8'd1);
    check("both_gnt_b", {7'd0, b_gnt}, 8'd0);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      {a_ss, a_sclk, a_mosi} = tv[i].a;
      {b_ss, b_sclk, b_mosi} = tv[i].b;
      pq.push_back(tv[i].exp);
      @(negedge clk);
      e = pq.pop_front();
      check($sformatf("pass_v%0d", i),
            {5'd0, spi_ss, spi_sclk, spi_mosi}, {5'd0, e});
      check($sformatf("b_ignored_v%0d", i), {7'd0, b_gnt}, 8'd0);
    end

    // A lets go; B waits out the gap with its ss held low
    @(posedge clk); #1;
    a_req = 1'b0;
    {a_ss, a_sclk, a_mosi} = 3'b100;
    {b_ss, b_sclk, b_mosi} = 3'b011;
    @(posedge clk);
    @(negedge clk);
    check("drop_gnt_a", {7'd0, a_gnt}, 8'd0);
    check("gap0_pads", {5'd0, spi_ss, spi_sclk, spi_mosi}, 8'd4);
    j = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_gnt) begin
        j = k;
        break;
      end
      if ({spi_ss, spi_sclk, spi_mosi} != 3'b100) seen = 1'b1;
    end
    check("gap_pads_idle", {7'd0, seen}, 8'd0);
    check("gap_to_gnt_b", 8'(j), 8'd5);
    check("b_pass_ss", {7'd0, spi_ss}, 8'd0);

    // B holds req past the grant limit
    n = 1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_gnt) n++;
      else break;
    end
    check("tmo_len", 8'(n), 8'd10);
    check("tmo_pulse", {7'd0, tmo}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    check("tmo_single", {7'd0, tmo}, 8'd0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_gnt) seen = 1'b1;
    end
    check("blocked_b", {7'd0, seen}, 8'd0);

    @(posedge clk); #1;
    b_req = 1'b0;
    @(posedge clk); #1;
    b_req = 1'b1;
    gq.push_back(1'b1);
    @(posedge clk);
    @(negedge clk);
    check("unblock_gnt_b", {7'd0, b_gnt}, 8'd1);

    // flash reset during B grant is deferred past the gap
    @(posedge clk); #1;
    frst = 1'b1;
    a_req = 1'b1;
    gq.push_back(1'b0);
    @(posedge clk); #1;
    frst = 1'b0;
    @(negedge clk);
    check("frst_keep_b", {7'd0, b_gnt}, 8'd1);
    check("frst_keep_rst", {7'd0, spi_rst}, 8'd1);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("frst_drop_b", {7'd0, b_gnt}, 8'd0);
    j = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) check("frst_gap_ready", {7'd0, ready}, 8'd1);
      if (k == 4) begin
        check("frst_rst_pin", {7'd0, spi_rst}, 8'd0);
        check("frst_ready", {7'd0, ready}, 8'd0);
      end
      if (a_gnt) begin
        j = k;
        break;
      end
    end
    check("frst_to_gnt_a", 8'(j), 8'd85);

    // write protect follows input one cycle later
    @(posedge clk); #1;
    wprot = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("wp_on", {7'd0, spi_wp}, 8'd0);
    @(posedge clk); #1;
    wprot = 1'b0;
    {a_ss, a_sclk, a_mosi} = 3'b011;

    // io_reset mid-grant
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("ioreset_gnt_now", {7'd0, a_gnt}, 8'd0);
    check("ioreset_ss_now", {6'd0, spi_ss, spi_sclk}, 8'd2);
    @(posedge clk);
    @(negedge clk);
    check("ioreset_gnt", {7'd0, a_gnt}, 8'd0);
    check("ioreset_ss", {7'd0, spi_ss}, 8'd1);
    check("ioreset_rst_pin", {7'd0, spi_rst}, 8'd0);
    check("ioreset_wp", {7'd0, spi_wp}, 8'd0);
    a_req = 1'b0;
    release_seq();

    // A alone: grant one cycle later
    @(posedge clk); #1;
    a_req = 1'b1;
    gq.push_back(1'b0);
    @(posedge clk);
    @(negedge clk);
    check("alone_gnt_a", {7'd0, a_gnt}, 8'd1);
    check("alone_gnt_b", {7'd0, b_gnt}, 8'd0);
    @(posedge clk); #1;
    a_req = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("gq_drained", 8'(gq.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
